// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scan_sequencer
// Purpose  : Drives select/enable of a 3-to-8 decoder through a masked
//            time-multiplexed scan. Each position gets a blanking gap and
//            then a programmable dwell. Defining SCAN_FRAME_PULSE_EN adds
//            the frame_done output.
// Revision : 1.0 - initial release
// ============================================================================
module scan_sequencer #(
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         mask,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy
`ifdef SCAN_FRAME_PULSE_EN
    ,
    output logic               frame_done
`endif
);

    localparam int                   c_blank_w    = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [c_blank_w-1:0] c_blank_load = c_blank_w'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [c_blank_w-1:0] c_blank_one  = c_blank_w'(1);
    localparam logic [DWELL_W-1:0]   c_dwell_one  = DWELL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BLANK  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t               r_state,     w_state_nxt;
    logic [2:0]           r_sel,       w_sel_nxt;
    logic                 r_en,        w_en_nxt;
    logic                 r_busy;
    logic [c_blank_w-1:0] r_blank_cnt, w_blank_cnt_nxt;
    logic [DWELL_W-1:0]   r_dwell_cnt, w_dwell_cnt_nxt;
    logic [2:0]           w_first;
    logic [2:0]           w_after;
    logic [DWELL_W-1:0]   w_dwell_eff;
`ifdef SCAN_FRAME_PULSE_EN
    logic                 r_frame,     w_frame_nxt;
`endif

    assign w_dwell_eff = (dwell == '0) ? c_dwell_one : dwell;

    // Lowest set mask bit, and lowest set bit strictly above the current select
    // (falling back to the lowest bit when the scan has to wrap).
    always_comb begin
        w_first = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) w_first = 3'(i);
        end
    end

    always_comb begin
        w_after = w_first;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i > int'(r_sel))) w_after = 3'(i);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_en_nxt        = r_en;
        w_blank_cnt_nxt = r_blank_cnt;
        w_dwell_cnt_nxt = r_dwell_cnt;
`ifdef SCAN_FRAME_PULSE_EN
        w_frame_nxt     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_sel_nxt = 3'd0;
                w_en_nxt  = 1'b0;
                if (run && |mask) begin
                    w_sel_nxt = w_first;
                    if (BLANK_CYCLES == 0) begin
                        w_state_nxt     = S_ACTIVE;
                        w_en_nxt        = 1'b1;
                        w_dwell_cnt_nxt = w_dwell_eff;
                    end else begin
                        w_state_nxt     = S_BLANK;
                        w_blank_cnt_nxt = c_blank_load;
                    end
                end
            end
            S_BLANK: begin
                if (!run) begin
                    w_state_nxt     = S_IDLE;
                    w_sel_nxt       = 3'd0;
                    w_en_nxt        = 1'b0;
                    w_blank_cnt_nxt = '0;
                end else if (r_blank_cnt == '0) begin
                    w_state_nxt     = S_ACTIVE;
                    w_en_nxt        = 1'b1;
                    w_dwell_cnt_nxt = w_dwell_eff;
                end else begin
                    w_blank_cnt_nxt = r_blank_cnt - c_blank_one;
                end
            end
            S_ACTIVE: begin
                if (!run || ((r_dwell_cnt == c_dwell_one) && !(|mask))) begin
                    w_state_nxt     = S_IDLE;
                    w_sel_nxt       = 3'd0;
                    w_en_nxt        = 1'b0;
                    w_dwell_cnt_nxt = '0;
                end else if (r_dwell_cnt == c_dwell_one) begin
                    // Without a gap the select moves on the same edge the next dwell starts.
                    w_sel_nxt = w_after;
`ifdef SCAN_FRAME_PULSE_EN
                    w_frame_nxt = (w_after <= r_sel);
`endif
                    if (BLANK_CYCLES == 0) begin
                        w_dwell_cnt_nxt = w_dwell_eff;
                    end else begin
                        w_state_nxt     = S_BLANK;
                        w_en_nxt        = 1'b0;
                        w_blank_cnt_nxt = c_blank_load;
                    end
                end else begin
                    w_dwell_cnt_nxt = r_dwell_cnt - c_dwell_one;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sel_nxt   = 3'd0;
                w_en_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sel       <= 3'd0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_blank_cnt <= '0;
            r_dwell_cnt <= '0;
`ifdef SCAN_FRAME_PULSE_EN
            r_frame     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_en        <= w_en_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_blank_cnt <= w_blank_cnt_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
`ifdef SCAN_FRAME_PULSE_EN
            r_frame     <= w_frame_nxt;
`endif
        end
    end

    assign sel  = r_sel;
    assign en   = r_en;
    assign busy = r_busy;
`ifdef SCAN_FRAME_PULSE_EN
    assign frame_done = r_frame;
`endif

endmodule
`default_nettype wire
